// File: rtl/mailbox_sender.sv
// Register-bus initiator that posts one message into a mailbox: writes the letters,
// rings the receiver doorbell, waits for the receiver's acknowledge and clears it.
package mailbox_sender_pkg;
    typedef struct packed {
        logic [31:0] addr;
        logic        write;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
        logic        valid;
    } reg_req_t;

    typedef struct packed {
        logic [31:0] rdata;
        logic        error;
        logic        ready;
    } reg_rsp_t;
endpackage

module mailbox_sender #(
    parameter type                  reg_req_t    = mailbox_sender_pkg::reg_req_t,
    parameter type                  reg_rsp_t    = mailbox_sender_pkg::reg_rsp_t,
    parameter int unsigned          AddrWidth    = 32,
    parameter int unsigned          NumLetters   = 2,
    parameter logic [AddrWidth-1:0] MboxBase     = '0,
    parameter logic [7:0]           LetterOffset = 8'h20,
    parameter logic [7:0]           RcvSetOffset = 8'h10,
    parameter logic [7:0]           SndClrOffset = 8'h08,
    parameter int unsigned          AckTimeout   = 1024
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     send_valid_i,
    output logic                     send_ready_o,
    input  logic [7:0]               mbox_id_i,
    input  logic [32*NumLetters-1:0] letters_i,
    input  logic                     snd_irq_i,
    output logic                     busy_o,
    output logic                     done_o,
    output logic                     err_o,
    output reg_req_t                 reg_req_o,
    input  reg_rsp_t                 reg_rsp_i
);

    typedef enum logic [2:0] {
        IDLE,
        WR_LETTER,
        RING,
        WAIT_ACK,
        CLR_ACK,
        DONE,
        ERR
    } state_e;

    localparam logic [4:0]  LastIdx     = 5'(NumLetters - 1);
    localparam logic [31:0] TimeoutLast = 32'(AckTimeout - 1);

    state_e                  state;
    reg_req_t                req_q;
    logic [7:0]              mbox_q;
    logic [32*NumLetters-1:0] letters_q;
    logic [4:0]              letter_idx;
    logic [31:0]             wait_cnt;
    logic                    unused_rdata;

    function automatic logic [AddrWidth-1:0] mbox_addr(input logic [7:0] id,
                                                       input logic [7:0] off);
        return MboxBase + (AddrWidth'(id) << 8) + AddrWidth'(off);
    endfunction

    function automatic reg_req_t write_req(input logic [AddrWidth-1:0] addr,
                                           input logic [31:0] data);
        reg_req_t r;
        r       = '0;
        r.addr  = addr;
        r.write = 1'b1;
        r.wdata = data;
        r.wstrb = 4'hF;
        r.valid = 1'b1;
        return r;
    endfunction

    // Letters are consumed from the bottom of letters_q, which shifts down one word per beat.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state      <= IDLE;
            req_q      <= '0;
            mbox_q     <= '0;
            letters_q  <= '0;
            letter_idx <= '0;
            wait_cnt   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (send_valid_i) begin
                        mbox_q     <= mbox_id_i;
                        letters_q  <= letters_i >> 32;
                        letter_idx <= '0;
                        req_q      <= write_req(mbox_addr(mbox_id_i, LetterOffset), letters_i[31:0]);
                        state      <= WR_LETTER;
                    end
                end
                WR_LETTER: begin
                    if (reg_rsp_i.ready) begin
                        if (reg_rsp_i.error) begin
                            req_q <= '0;
                            state <= ERR;
                        end else if (letter_idx == LastIdx) begin
                            req_q <= write_req(mbox_addr(mbox_q, RcvSetOffset), 32'h1);
                            state <= RING;
                        end else begin
                            letter_idx  <= letter_idx + 5'd1;
                            req_q.addr  <= req_q.addr + AddrWidth'(4);
                            req_q.wdata <= letters_q[31:0];
                            letters_q   <= letters_q >> 32;
                        end
                    end
                end
                RING: begin
                    if (reg_rsp_i.ready) begin
                        req_q    <= '0;
                        wait_cnt <= '0;
                        state    <= reg_rsp_i.error ? ERR : WAIT_ACK;
                    end
                end
                WAIT_ACK: begin
                    // The ack is a level, so one already pending is taken on the first cycle here.
                    if (snd_irq_i) begin
                        req_q <= write_req(mbox_addr(mbox_q, SndClrOffset), 32'h1);
                        state <= CLR_ACK;
                    end else if (AckTimeout != 0 && wait_cnt == TimeoutLast) begin
                        state <= ERR;
                    end else begin
                        wait_cnt <= wait_cnt + 32'd1;
                    end
                end
                CLR_ACK: begin
                    if (reg_rsp_i.ready) begin
                        req_q <= '0;
                        state <= reg_rsp_i.error ? ERR : DONE;
                    end
                end
                DONE:    state <= IDLE;
                ERR:     state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    assign send_ready_o = (state == IDLE);
    assign busy_o       = (state != IDLE);
    assign done_o       = (state == DONE);
    assign err_o        = (state == ERR);
    assign reg_req_o    = req_q;
    assign unused_rdata = ^reg_rsp_i.rdata;

endmodule

// File: tb/tb_mailbox_sender.sv
// Directed bench for mailbox_sender: bus write sequence, stalls, bus error, ack timeout,
// pre-raised ack and asynchronous reset mid-transfer.
module tb_mailbox_sender;
    import mailbox_sender_pkg::*;

    localparam int NL = 2;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            send_valid = 1'b0;
    logic [7:0]      mbox_id = '0;
    logic [32*NL-1:0] letters = '0;
    logic            snd_irq = 1'b0;
    logic            send_ready, busy, done, err;
    logic            z_send_ready, z_busy, z_done, z_err;
    reg_req_t        req, z_req;
    reg_rsp_t        rsp;
    logic            rsp_ready = 1'b0;
    logic            rsp_error = 1'b0;

    // bus responder modes
    bit              stall_en = 1'b0;
    bit              hold_low = 1'b0;
    int              err_at = -1;
    int              stall_cnt = 0;

    // scoreboard
    logic [63:0]     exp_q[$];
    logic [63:0]     got_q[$];
    int              beat_cnt, done_cnt, err_cnt, z_err_cnt, attr_err, stab_err;
    int              cyc = 0;
    logic            have_prev = 1'b0;
    logic [68:0]     prev_req;
    int              checks = 0;
    int              errors = 0;

    assign rsp = '{rdata: 32'h0, error: rsp_error, ready: rsp_ready};

    always #5 clk = ~clk;

    mailbox_sender #(.NumLetters(NL), .AckTimeout(8)) u_dut (
        .clk_i(clk), .rst_i(rst), .send_valid_i(send_valid), .send_ready_o(send_ready),
        .mbox_id_i(mbox_id), .letters_i(letters), .snd_irq_i(snd_irq), .busy_o(busy),
        .done_o(done), .err_o(err), .reg_req_o(req), .reg_rsp_i(rsp)
    );

    mailbox_sender #(.NumLetters(NL), .AckTimeout(0)) u_dut0 (
        .clk_i(clk), .rst_i(rst), .send_valid_i(send_valid), .send_ready_o(z_send_ready),
        .mbox_id_i(mbox_id), .letters_i(letters), .snd_irq_i(snd_irq), .busy_o(z_busy),
        .done_o(z_done), .err_o(z_err), .reg_req_o(z_req), .reg_rsp_i(rsp)
    );

    // bus monitor: records completed writes and checks stability while stalled
    always @(posedge clk) begin
        cyc++;
        if (!rst) begin
            if (done) done_cnt++;
            if (err) err_cnt++;
            if (z_err) z_err_cnt++;
            if (req.valid) begin
                if (have_prev && {req.addr, req.wdata, req.write, req.wstrb} != prev_req) stab_err++;
                prev_req  = {req.addr, req.wdata, req.write, req.wstrb};
                have_prev = !rsp_ready;
                if (rsp_ready) begin
                    got_q.push_back({req.addr, req.wdata});
                    beat_cnt++;
                    if (req.write !== 1'b1 || req.wstrb !== 4'hF) attr_err++;
                end
            end
        end
    end

    // bus responder: ready/error updated mid-cycle
    always @(negedge clk) begin
        rsp_error = (err_at >= 0) && (beat_cnt == err_at);
        if (hold_low) rsp_ready = 1'b0;
        else if (!stall_en) rsp_ready = 1'b1;
        else if (rsp_ready) begin
            rsp_ready = 1'b0;
            stall_cnt = req.valid ? 1 : 0;
        end else if (req.valid) begin
            if (stall_cnt == 3) rsp_ready = 1'b1;
            else stall_cnt++;
        end
    end

    task automatic clear_sb(input bit stall, input bit hold, input int e_at);
        stall_en = stall; hold_low = hold; err_at = e_at; stall_cnt = 0;
        exp_q.delete(); got_q.delete();
        beat_cnt = 0; done_cnt = 0; err_cnt = 0; z_err_cnt = 0;
        attr_err = 0; stab_err = 0; have_prev = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1; send_valid = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic send(input logic [7:0] id, input logic [63:0] lt, output int acc_cyc);
        send_valid = 1'b1; mbox_id = id; letters = lt; acc_cyc = cyc;
        checks++;
        if (send_ready !== 1'b1) begin
            errors++; $display("FAIL send_ready_at_accept: got %0b exp 1", send_ready);
        end
        @(negedge clk);
        send_valid = 1'b0; mbox_id = '0; letters = '0;
    endtask

    task automatic wait_flag(input bit want_err, input int budget, output int at_cyc);
        at_cyc = -1;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if ((want_err ? err : done) === 1'b1) begin
                at_cyc = cyc;
                break;
            end
        end
    endtask

    task automatic wait_beats(input int n, input int budget, output int at_cyc);
        at_cyc = -1;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (beat_cnt >= n) begin
                at_cyc = cyc;
                break;
            end
        end
    endtask

    function automatic int first_diff();
        if (got_q.size() != exp_q.size()) return (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
        for (int i = 0; i < exp_q.size(); i++) if (got_q[i] !== exp_q[i]) return i;
        return -1;
    endfunction

    task automatic test_reset();
        clear_sb(0, 0, -1);
        rst = 1'b1; send_valid = 1'b0; snd_irq = 1'b0;
        @(negedge clk);
        checks++; if (send_ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %0b exp 1", send_ready); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %0b exp 0", busy); end
        checks++; if (done !== 1'b0 || err !== 1'b0) begin errors++; $display("FAIL reset_pulses: got done=%0b err=%0b exp 0 0", done, err); end
        checks++; if (req !== '0) begin errors++; $display("FAIL reset_req: got %h exp 0", req); end
        rst = 1'b0;
        @(negedge clk);
        checks++; if (send_ready !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL idle_after_reset: got ready=%0b busy=%0b exp 1 0", send_ready, busy); end
    endtask

    task automatic test_basic();
        int acc, w, d;
        clear_sb(0, 0, -1); snd_irq = 1'b0;
        do_reset();
        exp_q.push_back({32'h320, 32'hA}); exp_q.push_back({32'h324, 32'hB});
        exp_q.push_back({32'h310, 32'h1}); exp_q.push_back({32'h308, 32'h1});
        send(8'd3, {32'hB, 32'hA}, acc);
        @(negedge clk);
        send_valid = 1'b1; mbox_id = 8'd7; letters = '1;
        checks++; if (send_ready !== 1'b0) begin errors++; $display("FAIL busy_not_ready: got %0b exp 0", send_ready); end
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL busy_flag: got %0b exp 1", busy); end
        @(negedge clk);
        send_valid = 1'b0; mbox_id = '0; letters = '0;
        wait_beats(3, 50, w);
        checks++; if (w < 0) begin errors++; $display("FAIL ring_seen: got timeout exp ring write"); end
        repeat (4) @(negedge clk);
        checks++; if (beat_cnt !== 3 || done !== 1'b0) begin errors++; $display("FAIL wait_ack_idle: got beats=%0d done=%0b exp 3 0", beat_cnt, done); end
        snd_irq = 1'b1;
        wait_flag(0, 20, d);
        checks++; if (d < 0) begin errors++; $display("FAIL basic_done: got timeout exp done pulse"); end
        @(negedge clk);
        snd_irq = 1'b0;
        checks++; if (done !== 1'b0 || send_ready !== 1'b1 || busy !== 1'b0) begin
            errors++; $display("FAIL basic_after_done: got done=%0b ready=%0b busy=%0b exp 0 1 0", done, send_ready, busy);
        end
        repeat (3) @(negedge clk);
        checks++; if (first_diff() != -1) begin errors++; $display("FAIL basic_writes: got %0d writes exp %0d, first diff at %0d", got_q.size(), exp_q.size(), first_diff()); end
        checks++; if (done_cnt !== 1 || err_cnt !== 0) begin errors++; $display("FAIL basic_pulses: got done=%0d err=%0d exp 1 0", done_cnt, err_cnt); end
        checks++; if (attr_err !== 0) begin errors++; $display("FAIL basic_write_attr: got %0d bad beats exp 0", attr_err); end
    endtask

    task automatic test_stall();
        int acc, d;
        clear_sb(1, 0, -1); snd_irq = 1'b1;
        do_reset();
        exp_q.push_back({32'h1220, 32'h12345678}); exp_q.push_back({32'h1224, 32'hDEADBEEF});
        exp_q.push_back({32'h1210, 32'h1});        exp_q.push_back({32'h1208, 32'h1});
        send(8'h12, {32'hDEADBEEF, 32'h12345678}, acc);
        wait_flag(0, 100, d);
        checks++; if (d - acc !== 18) begin errors++; $display("FAIL stall_latency: got %0d exp 18", d - acc); end
        snd_irq = 1'b0;
        repeat (2) @(negedge clk);
        checks++; if (stab_err !== 0) begin errors++; $display("FAIL stall_stable: got %0d changes exp 0", stab_err); end
        checks++; if (first_diff() != -1) begin errors++; $display("FAIL stall_writes: got %0d writes exp %0d, first diff at %0d", got_q.size(), exp_q.size(), first_diff()); end
        checks++; if (done_cnt !== 1 || err_cnt !== 0) begin errors++; $display("FAIL stall_pulses: got done=%0d err=%0d exp 1 0", done_cnt, err_cnt); end
    endtask

    task automatic test_bus_error();
        int acc, e;
        clear_sb(0, 0, 1); snd_irq = 1'b0;
        do_reset();
        exp_q.push_back({32'h320, 32'hA}); exp_q.push_back({32'h324, 32'hB});
        send(8'd3, {32'hB, 32'hA}, acc);
        wait_flag(1, 20, e);
        checks++; if (e - acc !== 3) begin errors++; $display("FAIL error_latency: got %0d exp 3", e - acc); end
        @(negedge clk);
        checks++; if (err !== 1'b0 || send_ready !== 1'b1 || busy !== 1'b0) begin
            errors++; $display("FAIL error_to_idle: got err=%0b ready=%0b busy=%0b exp 0 1 0", err, send_ready, busy);
        end
        repeat (3) @(negedge clk);
        checks++; if (first_diff() != -1) begin errors++; $display("FAIL error_writes: got %0d writes exp %0d, first diff at %0d", got_q.size(), exp_q.size(), first_diff()); end
        checks++; if (done_cnt !== 0 || err_cnt !== 1) begin errors++; $display("FAIL error_pulses: got done=%0d err=%0d exp 0 1", done_cnt, err_cnt); end
    endtask

    task automatic test_timeout();
        int acc, w, e;
        clear_sb(0, 0, -1); snd_irq = 1'b0;
        do_reset();
        exp_q.push_back({32'h520, 32'h1}); exp_q.push_back({32'h524, 32'h2});
        exp_q.push_back({32'h510, 32'h1});
        send(8'd5, {32'h2, 32'h1}, acc);
        wait_beats(3, 50, w);
        wait_flag(1, 30, e);
        checks++; if (w < 0 || e - w !== 8) begin errors++; $display("FAIL timeout_cycles: got %0d exp 8", e - w); end
        repeat (3) @(negedge clk);
        checks++; if (first_diff() != -1) begin errors++; $display("FAIL timeout_writes: got %0d writes exp %0d, first diff at %0d", got_q.size(), exp_q.size(), first_diff()); end
        checks++; if (err_cnt !== 1 || done_cnt !== 0) begin errors++; $display("FAIL timeout_pulses: got err=%0d done=%0d exp 1 0", err_cnt, done_cnt); end
        checks++; if (z_err_cnt !== 0 || z_busy !== 1'b1) begin errors++; $display("FAIL no_timeout_waits: got err=%0d busy=%0b exp 0 1", z_err_cnt, z_busy); end
    endtask

    task automatic test_irq_high();
        int acc, d;
        clear_sb(0, 0, -1); snd_irq = 1'b1;
        do_reset();
        exp_q.push_back({32'h120, 32'h66}); exp_q.push_back({32'h124, 32'h77});
        exp_q.push_back({32'h110, 32'h1});  exp_q.push_back({32'h108, 32'h1});
        send(8'd1, {32'h77, 32'h66}, acc);
        wait_flag(0, 20, d);
        checks++; if (d - acc !== 6) begin errors++; $display("FAIL irq_high_latency: got %0d exp 6", d - acc); end
        checks++; if (z_done !== 1'b1) begin errors++; $display("FAIL irq_high_no_timeout_done: got %0b exp 1", z_done); end
        snd_irq = 1'b0;
        repeat (2) @(negedge clk);
        checks++; if (first_diff() != -1) begin errors++; $display("FAIL irq_high_writes: got %0d writes exp %0d, first diff at %0d", got_q.size(), exp_q.size(), first_diff()); end
    endtask

    task automatic test_reset_mid();
        int acc;
        clear_sb(0, 1, -1); snd_irq = 1'b0;
        do_reset();
        send(8'd3, {32'hB, 32'hA}, acc);
        @(negedge clk);
        checks++; if (req.valid !== 1'b1 || busy !== 1'b1) begin errors++; $display("FAIL stalled_letter: got valid=%0b busy=%0b exp 1 1", req.valid, busy); end
        #2 rst = 1'b1;
        #1;
        checks++; if (req.valid !== 1'b0 || z_req.valid !== 1'b0) begin errors++; $display("FAIL async_valid_drop: got %0b/%0b exp 0/0", req.valid, z_req.valid); end
        checks++; if (busy !== 1'b0 || send_ready !== 1'b1) begin errors++; $display("FAIL async_idle: got busy=%0b ready=%0b exp 0 1", busy, send_ready); end
        @(negedge clk);
        rst = 1'b0; hold_low = 1'b0;
        repeat (4) @(negedge clk);
        checks++; if (done_cnt !== 0 || err_cnt !== 0 || beat_cnt !== 0) begin
            errors++; $display("FAIL reset_mid_quiet: got done=%0d err=%0d beats=%0d exp 0 0 0", done_cnt, err_cnt, beat_cnt);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_stall();
        test_bus_error();
        test_timeout();
        test_irq_high();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
